// File: rtl/audio_rate_gen.sv
// audio_rate_gen: sample-period tick generator with a one-deep prefetch buffer
// between the sample-memory reader and the audio codec path.
module audio_rate_gen #(
   parameter int unsigned MIN_DIV = 16,
   parameter int unsigned DATA_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       clkDiv,
   input  logic              enable,
   output logic              sampleReq,
   input  logic              sampleAck,
   input  logic [DATA_W-1:0] sampleData,
   output logic [DATA_W-1:0] audioOut,
   output logic              audioValid,
   output logic              tick,
   output logic              overrun
);
   // state | meaning
   // REQ   | sampleReq high, waiting for the reader's ack
   // FULL  | one sample buffered, waiting for the next tick
   // GAP   | sample went straight to the output; one idle cycle before re-requesting
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_FULL = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [31:0] MIN_P = 32'(MIN_DIV);

   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       period_q, period_d;
   logic [31:0]       period_eff;
   logic              wrap;
   logic              tick_q;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] smp_q, smp_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              valid_q, valid_d;
   logic              over_q, over_d;

   // wrap marks the last cycle of a period; tick/audioValid register it so both
   // appear in the same cycle audioOut changes.
   always_comb begin
      period_eff = (period_q < MIN_P) ? MIN_P : period_q;
      wrap       = enable && (cnt_q == (period_eff - 32'd1));
      cnt_d      = (!enable || wrap) ? 32'd0 : cnt_q + 32'd1;
      period_d   = (!enable || wrap) ? clkDiv : period_q;
   end

   always_comb begin
      state_d = state_q;
      smp_d   = smp_q;
      out_d   = out_q;
      valid_d = 1'b0;
      over_d  = over_q;
      case (state_q)
         ST_REQ: begin
            if (wrap && sampleAck) begin
               out_d   = sampleData;
               valid_d = 1'b1;
               state_d = ST_GAP;
            end else if (wrap) begin
               over_d  = 1'b1;
            end else if (sampleAck) begin
               smp_d   = sampleData;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (wrap) begin
               out_d   = smp_q;
               valid_d = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_GAP:  state_d = ST_REQ;
         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= 32'd0;
         period_q <= MIN_P;
         tick_q   <= 1'b0;
         state_q  <= ST_REQ;
         smp_q    <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         tick_q   <= wrap;
         state_q  <= state_d;
         smp_q    <= smp_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         over_q   <= over_d;
      end
   end

   assign sampleReq  = (state_q == ST_REQ);
   assign tick       = tick_q;
   assign audioOut   = out_q;
   assign audioValid = valid_q;
   assign overrun    = over_q;

endmodule

// File: tb/tb_audio_rate_gen.sv
// Bench for audio_rate_gen: directed scenarios plus a randomized run compared
// cycle by cycle against a timestamp-based reference model.
module tb_audio_rate_gen;
   localparam int MIN_DIV = 16;
   localparam int DATA_W  = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [31:0]       clkDiv;
   logic              enable;
   logic              sampleReq;
   logic              sampleAck;
   logic [DATA_W-1:0] sampleData;
   logic [DATA_W-1:0] audioOut;
   logic              audioValid;
   logic              tick;
   logic              overrun;

   audio_rate_gen #(.MIN_DIV(MIN_DIV), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clkDiv     (clkDiv),
      .enable     (enable),
      .sampleReq  (sampleReq),
      .sampleAck  (sampleAck),
      .sampleData (sampleData),
      .audioOut   (audioOut),
      .audioValid (audioValid),
      .tick       (tick),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reader behaviour
   int          rd_lat = 2;
   bit          rd_hold = 1'b0;
   bit          rd_stray = 1'b0;
   int          rd_wait = 0;
   logic [7:0]  rd_next = 8'h11;

   // reference model: ticks happen when the number of enabled edges since the
   // last period start equals the effective period of the latched request
   longint      m_edge, m_start;
   logic [31:0] m_shadow;
   bit          m_tick, m_valid, m_over, m_full, m_gap;
   logic [7:0]  m_out, m_smp;

   function automatic longint eff(input logic [31:0] d);
      if (d < MIN_DIV) return MIN_DIV;
      return longint'(d);
   endfunction

   task automatic model_reset();
      m_edge = 0; m_start = 0; m_shadow = MIN_DIV;
      m_tick = 0; m_valid = 0; m_over = 0; m_full = 0; m_gap = 0;
      m_out = 8'h00; m_smp = 8'h00;
   endtask

   task automatic model_edge();
      bit tk, acc, ng;
      if (!reset_n) return;
      m_edge++;
      tk = 0;
      if (!enable) begin
         m_start = m_edge; m_shadow = clkDiv;
      end else if (m_edge - m_start == eff(m_shadow)) begin
         tk = 1; m_start = m_edge; m_shadow = clkDiv;
      end
      acc = sampleAck && !m_full && !m_gap;
      m_valid = 0; ng = 0;
      if (tk) begin
         if (m_full) begin
            m_out = m_smp; m_valid = 1; m_full = 0;
         end else if (acc) begin
            m_out = sampleData; m_valid = 1; ng = 1;
         end else begin
            m_over = 1;
         end
      end else if (acc) begin
         m_full = 1; m_smp = sampleData;
      end
      m_gap = ng;
      m_tick = tk;
   endtask

   // drive reader inputs for the coming edge, clock it, advance the model
   task automatic step();
      if (sampleReq) rd_wait++; else rd_wait = 0;
      if (sampleReq && !rd_hold && rd_wait > rd_lat) begin
         sampleAck = 1'b1; sampleData = rd_next; rd_next = rd_next + 8'h11; rd_wait = 0;
      end else if (!sampleReq && rd_stray && $urandom_range(0, 3) == 0) begin
         sampleAck = 1'b1; sampleData = 8'($urandom);
      end else begin
         sampleAck = 1'b0; sampleData = 8'($urandom);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; clkDiv = 32'd100;
      sampleAck = 1'b0; sampleData = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
      checks++; if (audioValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", audioValid); end
      checks++; if (audioOut !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", audioOut); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      @(negedge clk);
      reset_n = 1'b1;
      step();
      checks++; if (sampleReq !== 1'b1) begin failures++; $display("FAIL reset_req_after got=%b exp=1", sampleReq); end
   endtask

   task automatic test_nominal();
      int tq[$];
      logic [7:0] oq[$];
      clkDiv = 32'd100;
      repeat (3) step();
      enable = 1'b1;
      for (int i = 1; i <= 320; i++) begin
         step();
         if (tick === 1'b1) tq.push_back(i);
         if (audioValid === 1'b1) oq.push_back(audioOut);
         checks++;
         if (audioValid !== tick) begin failures++; $display("FAIL nom_valid_tick cyc=%0d valid=%b tick=%b", i, audioValid, tick); end
      end
      checks++;
      if (tq.size() != 3) begin failures++; $display("FAIL nom_tick_count got=%0d exp=3", tq.size()); end
      else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (tq[k] != 100 * (k + 1)) begin failures++; $display("FAIL nom_tick_time k=%0d got=%0d exp=%0d", k, tq[k], 100 * (k + 1)); end
         end
      end
      checks++;
      if (oq.size() != 3 || oq[0] !== 8'h11 || oq[1] !== 8'h22 || oq[2] !== 8'h33) begin
         failures++; $display("FAIL nom_out_seq got_n=%0d exp=11,22,33", oq.size());
      end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL nom_overrun got=%b exp=0", overrun); end
   endtask

   task automatic test_min_div();
      int n;
      logic [31:0] dv[2] = '{32'd5, 32'd0};
      for (int k = 0; k < 2; k++) begin
         clkDiv = dv[k];
         n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
         n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
         checks++;
         if (n != MIN_DIV) begin failures++; $display("FAIL min_div_period div=%0d got=%0d exp=%0d", dv[k], n, MIN_DIV); end
      end
   endtask

   task automatic test_period_change();
      int n;
      clkDiv = 32'd100;
      n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
      repeat (30) step();
      clkDiv = 32'd40;
      n = 30; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
      checks++; if (n != 100) begin failures++; $display("FAIL chg_cur_period got=%0d exp=100", n); end
      n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
      checks++; if (n != 40) begin failures++; $display("FAIL chg_next_period got=%0d exp=40", n); end
   endtask

   task automatic test_overrun();
      int n;
      logic [7:0] o0, d;
      rd_hold = 1'b1;
      o0 = audioOut;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_pre got=%b exp=0", overrun); end
      n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
      checks++; if (n != 40) begin failures++; $display("FAIL ovr_tick_time got=%0d exp=40", n); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
      checks++; if (audioValid !== 1'b0) begin failures++; $display("FAIL ovr_valid got=%b exp=0", audioValid); end
      checks++; if (audioOut !== o0) begin failures++; $display("FAIL ovr_out_held got=%h exp=%h", audioOut, o0); end
      repeat (39) step();
      checks++; if (sampleReq !== 1'b1) begin failures++; $display("FAIL ovr_req_held got=%b exp=1", sampleReq); end
      rd_hold = 1'b0; rd_lat = 0; d = rd_next;
      step();
      checks++; if (tick !== 1'b1) begin failures++; $display("FAIL ovr_late_tick got=%b exp=1", tick); end
      checks++; if (audioValid !== 1'b1) begin failures++; $display("FAIL ovr_late_valid got=%b exp=1", audioValid); end
      checks++; if (audioOut !== d) begin failures++; $display("FAIL ovr_late_out got=%h exp=%h", audioOut, d); end
      checks++; if (sampleReq !== 1'b0) begin failures++; $display("FAIL ovr_gap_req got=%b exp=0", sampleReq); end
      rd_lat = 2;
      step();
      checks++; if (sampleReq !== 1'b1) begin failures++; $display("FAIL ovr_after_gap_req got=%b exp=1", sampleReq); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_enable_pause();
      int n, tk_seen;
      clkDiv = 32'd100;
      n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
      repeat (70) step();
      enable = 1'b0;
      tk_seen = 0;
      repeat (50) begin step(); if (tick !== 1'b0) tk_seen++; end
      checks++; if (tk_seen != 0) begin failures++; $display("FAIL pause_ticks got=%0d exp=0", tk_seen); end
      enable = 1'b1;
      n = 0; do begin step(); n++; end while (tick !== 1'b1 && n < 300);
      checks++; if (n != 100) begin failures++; $display("FAIL pause_resume_period got=%0d exp=100", n); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL pause_overrun got=%b exp=1", overrun); end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0; while (sampleReq !== 1'b1 && n < 300) begin step(); n++; end
      checks++; if (sampleReq !== 1'b1) begin failures++; $display("FAIL rmid_req_pre got=%b exp=1", sampleReq); end
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rmid_overrun got=%b exp=0", overrun); end
      checks++; if (audioOut !== 8'h00) begin failures++; $display("FAIL rmid_out got=%h exp=00", audioOut); end
      checks++; if (tick !== 1'b0 || audioValid !== 1'b0) begin failures++; $display("FAIL rmid_pulses tick=%b valid=%b exp=0", tick, audioValid); end
      sampleAck = 1'b1; sampleData = 8'h5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1; sampleAck = 1'b0; rd_wait = 0; rd_next = 8'hC3; rd_lat = 2;
      step();
      checks++; if (sampleReq !== 1'b1) begin failures++; $display("FAIL rmid_req_after got=%b exp=1", sampleReq); end
      n = 1; while (tick !== 1'b1 && n < 300) begin step(); n++; end
      checks++; if (n != MIN_DIV) begin failures++; $display("FAIL rmid_first_tick got=%0d exp=%0d", n, MIN_DIV); end
      checks++; if (audioOut !== 8'hC3 || audioValid !== 1'b1) begin failures++; $display("FAIL rmid_first_out got=%h/%b exp=c3/1", audioOut, audioValid); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rmid_overrun_after got=%b exp=0", overrun); end
   endtask

   task automatic test_random();
      rd_stray = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) clkDiv = ($urandom_range(0, 5) == 0) ? 32'd100 : 32'($urandom_range(0, 40));
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         if ($urandom_range(0, 79) == 0) rd_hold = ~rd_hold;
         if ($urandom_range(0, 9) == 0) rd_lat = $urandom_range(0, 4);
         step();
         checks++; if (tick !== m_tick) begin failures++; $display("FAIL rnd_tick cyc=%0d got=%b exp=%b", i, tick, m_tick); end
         checks++; if (audioValid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, audioValid, m_valid); end
         checks++; if (audioOut !== m_out) begin failures++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", i, audioOut, m_out); end
         checks++; if (overrun !== m_over) begin failures++; $display("FAIL rnd_overrun cyc=%0d got=%b exp=%b", i, overrun, m_over); end
         checks++; if (sampleReq !== (!m_full && !m_gap)) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, sampleReq, !m_full && !m_gap); end
      end
      rd_stray = 1'b0; rd_hold = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_min_div();
      test_period_change();
      test_overrun();
      test_enable_pause();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/audio_rate_gen.md
AUDIO_RATE_GEN -- requirements
Module: audio_rate_gen

Interface
REQ-001 Parameter MIN_DIV, default 16: minimum allowed sample period, in clk cycles.
REQ-002 Parameter DATA_W, default 8: audio sample width.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clkDiv  input  32  sample-period request from the speed controller, in clk cycles per sample.
REQ-006 enable  input  1  high = generate sample ticks; low = pause.
REQ-007 sampleReq  output  1  level request to the sample-memory reader.
REQ-008 sampleAck  input  1  one-cycle pulse from the reader; sampleData is valid in the same cycle.
REQ-009 sampleData  input  DATA_W  sample returned by the reader.
REQ-010 audioOut  output  DATA_W  registered sample presented to the audio codec path.
REQ-011 audioValid  output  1  one-cycle pulse in the cycle audioOut takes a new value.
REQ-012 tick  output  1  one-cycle pulse marking each sample-period boundary.
REQ-013 overrun  output  1  sticky flag: a tick occurred with no sample available.

Function
REQ-014 Effective period P SHALL be max(periodReg, MIN_DIV), where periodReg is a 32-bit shadow of clkDiv.
REQ-015 periodReg SHALL load clkDiv only in a tick cycle or in any cycle with enable low; a clkDiv change mid-period SHALL take effect in the following period.
REQ-016 The 32-bit counter cnt SHALL increment each cycle while enable is high; when cnt == P-1, tick SHALL pulse and cnt SHALL wrap to 0.
REQ-017 With enable low, cnt SHALL be held at 0, tick SHALL stay 0, and any outstanding request SHALL still complete.
REQ-018 With constant clkDiv = D >= MIN_DIV, tick SHALL recur every D cycles exactly; with D < MIN_DIV (including 0), every MIN_DIV cycles.
REQ-019 The FSM SHALL have states REQ (sampleReq=1), FULL (sampleReq=0, one sample buffered) and GAP (sampleReq=0 for one cycle).
REQ-020 REQ, sampleAck=1, tick=0: buffer <= sampleData; next state FULL.
REQ-021 REQ, sampleAck=0, tick=1: overrun <= 1; audioOut held; audioValid=0; stay in REQ.
REQ-022 REQ, sampleAck=1 and tick=1 in the same cycle: audioOut <= sampleData directly; audioValid=1; no overrun; next state GAP.
REQ-023 FULL, tick=1: audioOut <= buffer; audioValid=1; next state REQ. FULL, tick=0: stay in FULL.
REQ-024 GAP SHALL always go to REQ after exactly one cycle.
REQ-025 sampleReq SHALL be low for at least one cycle after every accepted sampleAck; a sampleAck in FULL or GAP SHALL be ignored.
REQ-026 Each state is registered; sampleReq and audioValid SHALL be decoded from registered state and flags, with no combinational path from sampleAck to sampleReq.
REQ-027 overrun SHALL clear only on reset.
REQ-028 audioValid SHALL never assert without tick in the same cycle.

Reset
REQ-029 While reset_n is low, asynchronously: cnt=0, periodReg=MIN_DIV, FSM=REQ, buffer=0, audioOut=0, audioValid=0, tick=0, overrun=0.
REQ-030 sampleReq SHALL be 1 from the first cycle after reset release, so the buffer is prefetched before the first tick.
REQ-031 Reset asserted mid-handshake SHALL abandon the request; after release, a new request SHALL be issued and any late ack SHALL be ignored until then.

Verification
REQ-032 MIN_DIV=16, clkDiv=100, enable=1, reader acks 2 cycles after req, data 0x11, 0x22, ... -> ticks every 100 cycles; audioOut sequence 0x11, 0x22; audioValid coincident with tick; overrun=0.
REQ-033 clkDiv=5, then 0 -> ticks every 16 cycles in both cases.
REQ-034 clkDiv changes 100 -> 40 at cnt=30 -> current period completes at 100 cycles; the next period is 40 cycles.
REQ-035 Reader withholds ack across one tick -> overrun=1 from that tick on; audioOut unchanged; a later ack coincident with a tick -> audioOut updated, audioValid=1, sampleReq low 1 cycle (GAP) then high.
REQ-036 enable low for 50 cycles at cnt=70 -> no ticks; cnt=0; after enable rises, the first tick arrives P cycles later.
REQ-037 reset_n pulsed low while sampleReq=1 -> all outputs return to reset values immediately; sampleReq=1 on the first cycle after release.
